// File: rtl/lab9_soc_pio_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a timed pulse engine that
// inverts masked bits for PULSE_LEN cycles, then raises a sticky done flag.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no pulse running, pmask = 0, PULSE writes may start one
// S_ACTIVE | masked bits inverted, cnt counting down to terminal 1
module lab9_soc_pio_pulse #(
  parameter int unsigned       WIDTH         = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
  parameter int unsigned       CNT_W         = 16,
  parameter logic [CNT_W-1:0]  DEFAULT_PULSE = CNT_W'(1000)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_LEN    = 3'd1;
  localparam logic [2:0] A_PULSE  = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;
  localparam logic [2:0] A_OUTSET = 3'd5;
  localparam logic [2:0] A_OUTCLR = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_pmask;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pulse_len;
  logic             r_done;
  logic             r_irq_en;

  logic             w_wr;
  logic [WIDTH-1:0] w_mask;
  logic [CNT_W-1:0] w_len;
  logic             w_start;
  logic             w_last;
  logic             w_busy;
  logic             w_done_set;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_mask   = writedata[WIDTH-1:0];
  assign w_len    = writedata[CNT_W-1:0];
  assign w_unused = ^writedata;

  // Zero mask or zero length never leaves IDLE; writes while ACTIVE are dropped.
  assign w_start = w_wr && (address == A_PULSE) && (r_state == S_IDLE) &&
                   (|w_mask) && (|r_pulse_len);
  assign w_last  = (r_state == S_ACTIVE) && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_last)  w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state == S_ACTIVE);
    w_done_set = w_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= RESET_VALUE;
      r_pulse_len <= DEFAULT_PULSE;
      r_irq_en    <= 1'b0;
    end else if (w_wr) begin
      case (address)
        A_DATA:   r_data      <= w_mask;
        A_OUTSET: r_data      <= r_data | w_mask;
        A_OUTCLR: r_data      <= r_data & ~w_mask;
        A_LEN:    r_pulse_len <= w_len;
        A_CTRL:   r_irq_en    <= writedata[0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pmask <= '0;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_pmask <= w_mask;
      r_cnt   <= r_pulse_len;
    end else if (w_last) begin
      r_pmask <= '0;
      r_cnt   <= '0;
    end else if (w_busy) begin
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // Completion beats a same-cycle W1C so a finishing pulse is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_done <= 1'b0;
    else if (w_done_set)
      r_done <= 1'b1;
    else if (w_wr && (address == A_STATUS) && writedata[1])
      r_done <= 1'b0;
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata = 32'(r_data);
      A_LEN:    readdata = 32'(r_pulse_len);
      A_PULSE:  readdata = 32'(r_pmask);
      A_STATUS: readdata = {30'd0, r_done, w_busy};
      A_CTRL:   readdata = {31'd0, r_irq_en};
      default:  readdata = '0;
    endcase
  end

  assign out_port = r_data ^ r_pmask;
  assign irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_lab9_soc_pio_pulse.sv
// Bench for lab9_soc_pio_pulse (WIDTH=8, RESET_VALUE=A5): table vectors and
// hand sequences share one apply task that queues expectations per bus cycle.
module tb_lab9_soc_pio_pulse;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic        exp_irq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tbl[$];

  lab9_soc_pio_pulse #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .CNT_W(16), .DEFAULT_PULSE(16'd1000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] a, input logic [31:0] d,
                              input logic chk, input logic [31:0] er,
                              input logic [7:0] eo, input logic ei);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.chk_rd = chk;
    v.exp_rd = er; v.exp_out = eo; v.exp_irq = ei;
    return v;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    logic [31:0] rd_seen;
    chipselect = 1'b1;
    write_n    = ~v.wr;
    address    = v.addr;
    writedata  = v.wdata;
    sb.push_back(v);
    @(negedge clk);
    rd_seen = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    e = sb.pop_front();
    if (e.chk_rd) check({tag, " readdata"}, rd_seen, e.exp_rd);
    check({tag, " out_port"}, 32'(out_port), 32'(e.exp_out));
    check({tag, " irq"}, 32'(irq), 32'(e.exp_irq));
  endtask

  initial begin
    // wr, addr, wdata, chk_rd, exp_rd, exp_out (after edge), exp_irq
    tbl.push_back(mk(0, 3'd1, 32'h0,         1, 32'd1000,      8'hA5, 0));
    tbl.push_back(mk(0, 3'd3, 32'h0,         1, 32'h0,         8'hA5, 0));
    tbl.push_back(mk(0, 3'd0, 32'h0,         1, 32'h0000_00A5, 8'hA5, 0));
    tbl.push_back(mk(1, 3'd0, 32'hFFFF_FF3C, 0, 32'h0,         8'h3C, 0));
    tbl.push_back(mk(0, 3'd0, 32'h0,         1, 32'h0000_003C, 8'h3C, 0));
    tbl.push_back(mk(1, 3'd5, 32'h0000_0003, 0, 32'h0,         8'h3F, 0));
    tbl.push_back(mk(1, 3'd6, 32'h0000_0030, 0, 32'h0,         8'h0F, 0));
    tbl.push_back(mk(0, 3'd5, 32'h0,         1, 32'h0,         8'h0F, 0));
    tbl.push_back(mk(0, 3'd6, 32'h0,         1, 32'h0,         8'h0F, 0));
    tbl.push_back(mk(0, 3'd7, 32'h0,         1, 32'h0,         8'h0F, 0));
    tbl.push_back(mk(1, 3'd7, 32'hFFFF_FFFF, 0, 32'h0,         8'h0F, 0));
    tbl.push_back(mk(0, 3'd4, 32'h0,         1, 32'h0,         8'h0F, 0));
    tbl.push_back(mk(1, 3'd1, 32'd3,         0, 32'h0,         8'h0F, 0));
    tbl.push_back(mk(1, 3'd4, 32'h1,         0, 32'h0,         8'h0F, 0));
    tbl.push_back(mk(1, 3'd0, 32'h0,         0, 32'h0,         8'h00, 0));
    tbl.push_back(mk(1, 3'd2, 32'h81,        0, 32'h0,         8'h81, 0));
    tbl.push_back(mk(0, 3'd3, 32'h0,         1, 32'h1,         8'h81, 0));
    tbl.push_back(mk(0, 3'd2, 32'h0,         1, 32'h81,        8'h81, 0));
    tbl.push_back(mk(0, 3'd3, 32'h0,         1, 32'h1,         8'h00, 1));
    tbl.push_back(mk(0, 3'd3, 32'h0,         1, 32'h2,         8'h00, 1));
    tbl.push_back(mk(1, 3'd3, 32'h2,         0, 32'h0,         8'h00, 0));
    tbl.push_back(mk(0, 3'd3, 32'h0,         1, 32'h0,         8'h00, 0));
    tbl.push_back(mk(1, 3'd2, 32'h0,         0, 32'h0,         8'h00, 0));
    tbl.push_back(mk(0, 3'd3, 32'h0,         1, 32'h0,         8'h00, 0));
    tbl.push_back(mk(1, 3'd1, 32'h0,         0, 32'h0,         8'h00, 0));
    tbl.push_back(mk(1, 3'd2, 32'h1,         0, 32'h0,         8'h00, 0));
    tbl.push_back(mk(0, 3'd3, 32'h0,         1, 32'h0,         8'h00, 0));
    tbl.push_back(mk(0, 3'd1, 32'h0,         1, 32'h0,         8'h00, 0));

    repeat (3) @(posedge clk);
    #1;
    check("reset out_port", 32'(out_port), 32'hA5);
    check("reset irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Long pulse on bit0; retrigger at k=3 ignored, DATA write at k=4.
    apply(mk(1, 3'd1, 32'd10, 0, 32'h0, 8'h00, 0), "len10");
    for (int k = 0; k <= 11; k++) begin
      vec_t v;
      logic [7:0] eo;
      eo = (k >= 4 && k <= 9) ? 8'h00 : 8'h01;
      if (k == 0)      v = mk(1, 3'd2, 32'h01, 0, 32'h0, eo, 0);
      else if (k == 3) v = mk(1, 3'd2, 32'h02, 0, 32'h0, eo, 0);
      else if (k == 4) v = mk(1, 3'd0, 32'h01, 0, 32'h0, eo, 0);
      else if (k == 5) v = mk(0, 3'd2, 32'h0,  1, 32'h01, eo, 0);
      else if (k == 11) v = mk(0, 3'd3, 32'h0, 1, 32'h2, eo, 1);
      else             v = mk(0, 3'd3, 32'h0,  1, 32'h1, eo, (k >= 10));
      apply(v, $sformatf("long k%0d", k));
    end

    // W1C landing on the completion edge: set wins.
    apply(mk(1, 3'd3, 32'h2, 0, 32'h0, 8'h01, 0), "clr");
    apply(mk(1, 3'd1, 32'd2, 0, 32'h0, 8'h01, 0), "len2");
    apply(mk(1, 3'd2, 32'h04, 0, 32'h0, 8'h05, 0), "p04");
    apply(mk(0, 3'd3, 32'h0, 1, 32'h1, 8'h05, 0), "p04 busy");
    apply(mk(1, 3'd3, 32'h2, 0, 32'h0, 8'h01, 1), "w1c race");
    apply(mk(0, 3'd3, 32'h0, 1, 32'h2, 8'h01, 1), "race status");

    // Reset during cycle 2 of a 5-cycle pulse.
    apply(mk(1, 3'd3, 32'h2, 0, 32'h0, 8'h01, 0), "clr2");
    apply(mk(1, 3'd1, 32'd5, 0, 32'h0, 8'h01, 0), "len5");
    apply(mk(1, 3'd2, 32'h08, 0, 32'h0, 8'h09, 0), "p08");
    apply(mk(0, 3'd3, 32'h0, 1, 32'h1, 8'h09, 0), "p08 busy");
    address = 3'd3;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst out_port", 32'(out_port), 32'hA5);
    check("midrst status", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(0, 3'd3, 32'h0, 1, 32'h0, 8'hA5, 0), "post status");
    apply(mk(0, 3'd1, 32'h0, 1, 32'd1000, 8'hA5, 0), "post len");
    apply(mk(0, 3'd2, 32'h0, 1, 32'h0, 8'hA5, 0), "post pmask");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("post quiet out_port", 32'(out_port), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
